// File: rtl/ysyx_25040101_opnd_stage.sv
// Registered ALU operand stage sitting between decode and EX.
// Selects srcA/srcB, forwards from in-flight producers, parks an instruction
// in WAIT while a needed producer is still pending, and hands the operands to
// EX over a valid/ready handshake. Also counts the cycles spent stalled.
module ysyx_25040101_opnd_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NR_FWD = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             srca_ctrl_i,
  input  logic [2:0]             srcb_ctrl_i,
  input  logic                   store_i,
  input  logic [4:0]             rs1_addr_i,
  input  logic [4:0]             rs2_addr_i,
  input  logic [XLEN-1:0]        rs1_data_i,
  input  logic [XLEN-1:0]        rs2_data_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        imm_i,
  input  logic [NR_FWD-1:0]      fwd_valid_i,
  input  logic [NR_FWD-1:0]      fwd_pend_i,
  input  logic [5*NR_FWD-1:0]    fwd_rd_i,
  input  logic [XLEN*NR_FWD-1:0] fwd_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN-1:0]        srca_o,
  output logic [XLEN-1:0]        srcb_o,
  output logic [XLEN-1:0]        sdata_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [1:0] {StEmpty, StWait, StFull} state_e;

  typedef struct packed {
    logic            ok;
    logic [XLEN-1:0] val;
  } res_t;

  // Youngest matching producer wins; a pending winner leaves the operand unresolved.
  // x0 is hard-wired to zero and never forwarded.
  function automatic res_t resolve(input logic [4:0]             addr,
                                   input logic [XLEN-1:0]        rf,
                                   input logic [NR_FWD-1:0]      fv,
                                   input logic [NR_FWD-1:0]      fp,
                                   input logic [5*NR_FWD-1:0]    frd,
                                   input logic [XLEN*NR_FWD-1:0] fd);
    res_t r;
    r.ok  = 1'b1;
    r.val = rf;
    if (addr == 5'd0) begin
      r.val = '0;
    end else begin
      // Walk oldest to youngest so the lowest index overwrites last.
      for (int k = int'(NR_FWD) - 1; k >= 0; k--) begin
        if (fv[k] && (frd[5*k +: 5] == addr)) begin
          r.ok  = ~fp[k];
          r.val = fd[XLEN*k +: XLEN];
        end
      end
    end
    return r;
  endfunction

  state_e state_q, state_d;

  // Instruction fields parked while waiting on a producer.
  logic [1:0]      srca_ctrl_q;
  logic [2:0]      srcb_ctrl_q;
  logic            store_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, pc_q, imm_q;

  // Per-operand latch: once resolved, the value is frozen.
  logic            rs1_ok_q, rs2_ok_q;
  logic [XLEN-1:0] rs1_val_q, rs2_val_q;

  logic [XLEN-1:0]  srca_q, srcb_q, sdata_q;
  logic [CNT_W-1:0] cnt_q;

  // Operands of the instruction currently being evaluated.
  logic            in_wait;
  logic [1:0]      cur_srca_ctrl;
  logic [2:0]      cur_srcb_ctrl;
  logic            cur_store;
  logic [4:0]      cur_rs1_addr, cur_rs2_addr;
  logic [XLEN-1:0] cur_rs1_data, cur_rs2_data, cur_pc, cur_imm;

  res_t            rs1_res, rs2_res;
  logic            rs1_ok, rs2_ok, need_rs1, need_rs2, all_ok;
  logic [XLEN-1:0] rs1_v, rs2_v, srca_calc, srcb_calc;

  logic accept, load_out, load_hold, upd_wait;

  // Pick parked fields in WAIT, live decode fields otherwise.
  always_comb begin
    in_wait       = (state_q == StWait);
    cur_srca_ctrl = in_wait ? srca_ctrl_q : srca_ctrl_i;
    cur_srcb_ctrl = in_wait ? srcb_ctrl_q : srcb_ctrl_i;
    cur_store     = in_wait ? store_q     : store_i;
    cur_rs1_addr  = in_wait ? rs1_addr_q  : rs1_addr_i;
    cur_rs2_addr  = in_wait ? rs2_addr_q  : rs2_addr_i;
    cur_rs1_data  = in_wait ? rs1_data_q  : rs1_data_i;
    cur_rs2_data  = in_wait ? rs2_data_q  : rs2_data_i;
    cur_pc        = in_wait ? pc_q        : pc_i;
    cur_imm       = in_wait ? imm_q       : imm_i;
  end

  // Resolve both source registers and decide whether the instruction can issue.
  always_comb begin
    rs1_res  = resolve(cur_rs1_addr, cur_rs1_data, fwd_valid_i, fwd_pend_i, fwd_rd_i, fwd_data_i);
    rs2_res  = resolve(cur_rs2_addr, cur_rs2_data, fwd_valid_i, fwd_pend_i, fwd_rd_i, fwd_data_i);
    rs1_ok   = (in_wait & rs1_ok_q) | rs1_res.ok;
    rs2_ok   = (in_wait & rs2_ok_q) | rs2_res.ok;
    rs1_v    = (in_wait & rs1_ok_q) ? rs1_val_q : rs1_res.val;
    rs2_v    = (in_wait & rs2_ok_q) ? rs2_val_q : rs2_res.val;
    need_rs1 = (cur_srca_ctrl == 2'b00);
    need_rs2 = (cur_srcb_ctrl == 3'b000) | (cur_srcb_ctrl == 3'b100) | cur_store;
    all_ok   = (~need_rs1 | rs1_ok) & (~need_rs2 | rs2_ok);
  end

  // Operand muxes.
  always_comb begin
    srca_calc = '0;
    srcb_calc = '0;
    case (cur_srca_ctrl)
      2'b00:   srca_calc = rs1_v;
      2'b01:   srca_calc = cur_pc;
      default: srca_calc = '0;
    endcase
    case (cur_srcb_ctrl)
      3'b000:  srcb_calc = rs2_v;
      3'b001:  srcb_calc = cur_imm;
      3'b010:  srcb_calc = XLEN'(XLEN / 8);
      3'b100:  srcb_calc = {{(XLEN-ShW){1'b0}}, rs2_v[ShW-1:0]};
      default: srcb_calc = '0;
    endcase
  end

  assign in_ready_o  = ((state_q == StEmpty) | ((state_q == StFull) & out_ready_i)) & ~flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == StFull);

  // Next-state and load strobes; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_hold = 1'b0;
    upd_wait  = 1'b0;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty, StFull: begin
          if (accept) begin
            if (all_ok) begin
              state_d  = StFull;
              load_out = 1'b1;
            end else begin
              state_d   = StWait;
              load_hold = 1'b1;
            end
          end else if ((state_q == StFull) && out_ready_i) begin
            state_d = StEmpty;
          end
        end
        StWait: begin
          if (all_ok) begin
            state_d  = StFull;
            load_out = 1'b1;
          end else begin
            upd_wait = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // State register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StWait) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Parked instruction fields and per-operand resolved latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srca_ctrl_q <= '0;
      srcb_ctrl_q <= '0;
      store_q     <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_ok_q    <= 1'b0;
      rs2_ok_q    <= 1'b0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
    end else begin
      if (load_hold) begin
        srca_ctrl_q <= srca_ctrl_i;
        srcb_ctrl_q <= srcb_ctrl_i;
        store_q     <= store_i;
        rs1_addr_q  <= rs1_addr_i;
        rs2_addr_q  <= rs2_addr_i;
        rs1_data_q  <= rs1_data_i;
        rs2_data_q  <= rs2_data_i;
        pc_q        <= pc_i;
        imm_q       <= imm_i;
      end
      // rs*_v already returns the frozen value for operands resolved earlier.
      if (load_hold || upd_wait) begin
        rs1_ok_q  <= rs1_ok;
        rs2_ok_q  <= rs2_ok;
        rs1_val_q <= rs1_v;
        rs2_val_q <= rs2_v;
      end
    end
  end

  // Output operand registers, held stable while FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srca_q  <= '0;
      srcb_q  <= '0;
      sdata_q <= '0;
    end else if (load_out) begin
      srca_q  <= srca_calc;
      srcb_q  <= srcb_calc;
      sdata_q <= rs2_v;
    end
  end

  assign srca_o      = srca_q;
  assign srcb_o      = srcb_q;
  assign sdata_o     = sdata_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_ysyx_25040101_opnd_stage.sv
// Bench for the operand stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_ysyx_25040101_opnd_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NF   = 2;
  localparam int unsigned CW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              flush, in_valid, in_ready, store, out_valid, out_ready;
  logic [1:0]        srca_ctrl;
  logic [2:0]        srcb_ctrl;
  logic [4:0]        rs1_addr, rs2_addr;
  logic [31:0]       rs1_data, rs2_data, pc, imm, srca, srcb, sdata;
  logic [NF-1:0]     fwd_valid, fwd_pend;
  logic [5*NF-1:0]   fwd_rd;
  logic [32*NF-1:0]  fwd_data;
  logic [CW-1:0]     stall_cnt;

  ysyx_25040101_opnd_stage #(.XLEN(XLEN), .NR_FWD(NF), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .srca_ctrl_i(srca_ctrl), .srcb_ctrl_i(srcb_ctrl), .store_i(store),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .pc_i(pc), .imm_i(imm), .fwd_valid_i(fwd_valid), .fwd_pend_i(fwd_pend), .fwd_rd_i(fwd_rd),
    .fwd_data_i(fwd_data), .out_valid_o(out_valid), .out_ready_i(out_ready), .srca_o(srca),
    .srcb_o(srcb), .sdata_o(sdata), .stall_cnt_o(stall_cnt)
  );

  // 64-bit instance for the width-dependent constant and shift amount.
  logic        w_in_valid, w_in_ready, w_out_valid;
  logic [2:0]  w_srcb_ctrl;
  logic [63:0] w_rs2_data, w_srca, w_srcb, w_sdata;
  logic [15:0] w_cnt;

  ysyx_25040101_opnd_stage #(.XLEN(64), .NR_FWD(NF), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
    .srca_ctrl_i(2'b10), .srcb_ctrl_i(w_srcb_ctrl), .store_i(1'b0),
    .rs1_addr_i(5'd1), .rs2_addr_i(5'd2), .rs1_data_i(64'd0), .rs2_data_i(w_rs2_data),
    .pc_i(64'd0), .imm_i(64'd0), .fwd_valid_i(2'b00), .fwd_pend_i(2'b00), .fwd_rd_i(10'd0),
    .fwd_data_i(128'd0), .out_valid_o(w_out_valid), .out_ready_i(1'b1), .srca_o(w_srca),
    .srcb_o(w_srcb), .sdata_o(w_sdata), .stall_cnt_o(w_cnt)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Check the DUT and the model against one hand-computed value.
  task automatic pin(input string name, input logic [63:0] act, input logic [63:0] mdl,
                     input logic [63:0] exp);
    chk({name, " dut"}, act, exp);
    chk({name, " model"}, mdl, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  sa;
    logic [2:0]  sb;
    logic        st;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2, pc, imm;
  } ins_t;

  bit          m_busy, m_valid, m_ok1, m_ok2, m_sneed;
  ins_t        m_ins;
  logic [31:0] m_v1, m_v2, m_a, m_b, m_s;
  int          m_cnt;

  function automatic bit need1(input ins_t i);
    return i.sa == 2'b00;
  endfunction

  function automatic bit need2(input ins_t i);
    return (i.sb == 3'b000) || (i.sb == 3'b100) || i.st;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_ok1 = 0; m_ok2 = 0; m_sneed = 0; m_cnt = 0;
    m_v1 = 0; m_v2 = 0; m_a = 0; m_b = 0; m_s = 0;
  endtask

  task automatic resolve(input logic [4:0] addr, input logic [31:0] rf, output bit ok,
                         output logic [31:0] v);
    bit found = 0;
    ok = 1;
    v  = (addr == 0) ? 32'd0 : rf;
    if (addr != 0) begin
      for (int k = 0; k < int'(NF); k++) begin
        if (!found && fwd_valid[k] && fwd_rd[5*k +: 5] == addr) begin
          found = 1;
          ok    = !fwd_pend[k];
          v     = fwd_data[32*k +: 32];
        end
      end
    end
  endtask

  task automatic issue(input ins_t i, input logic [31:0] v1, input logic [31:0] v2);
    m_valid = 1;
    m_sneed = need2(i);
    m_s     = v2;
    m_a     = (i.sa == 2'b00) ? v1 : (i.sa == 2'b01) ? i.pc : 32'd0;
    case (i.sb)
      3'd0:    m_b = v2;
      3'd1:    m_b = i.imm;
      3'd2:    m_b = XLEN / 8;
      3'd4:    m_b = v2 % XLEN;
      default: m_b = 0;
    endcase
  endtask

  function automatic bit exp_ready();
    return ((!m_busy && !m_valid) || (m_valid && out_ready)) && !flush;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    bit          rdy, ok1, ok2;
    logic [31:0] v1, v2;
    ins_t        i;
    rdy = exp_ready();
    if (m_busy && m_cnt < (1 << CW) - 1) m_cnt++;
    if (flush) begin
      m_busy = 0;
      m_valid = 0;
    end else if (m_busy) begin
      if (!m_ok1) begin resolve(m_ins.a1, m_ins.d1, ok1, v1); if (ok1) begin m_ok1 = 1; m_v1 = v1; end end
      if (!m_ok2) begin resolve(m_ins.a2, m_ins.d2, ok2, v2); if (ok2) begin m_ok2 = 1; m_v2 = v2; end end
      if ((!need1(m_ins) || m_ok1) && (!need2(m_ins) || m_ok2)) begin
        issue(m_ins, m_v1, m_v2);
        m_busy = 0;
      end
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if (in_valid && rdy) begin
        i = '{sa: srca_ctrl, sb: srcb_ctrl, st: store, a1: rs1_addr, a2: rs2_addr,
              d1: rs1_data, d2: rs2_data, pc: pc, imm: imm};
        resolve(i.a1, i.d1, ok1, v1);
        resolve(i.a2, i.d2, ok2, v2);
        if ((!need1(i) || ok1) && (!need2(i) || ok2)) begin
          issue(i, v1, v2);
        end else begin
          m_busy = 1; m_ins = i; m_ok1 = ok1; m_ok2 = ok2; m_v1 = v1; m_v2 = v2;
        end
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_valid);
        chk("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) begin
          chk("srca", srca, m_a);
          chk("srcb", srcb, m_b);
          if (m_sneed) chk("sdata", sdata, m_s);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_in();
    flush = 0; in_valid = 0; out_ready = 1; store = 0;
    srca_ctrl = 2'b10; srcb_ctrl = 3'b111; rs1_addr = 0; rs2_addr = 0;
    rs1_data = 0; rs2_data = 0; pc = 0; imm = 0;
    fwd_valid = 0; fwd_pend = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " in_ready"}, in_ready, 1);
    chk({tag, " srca"}, srca, 0);
    chk({tag, " srcb"}, srcb, 0);
    chk({tag, " sdata"}, sdata, 0);
    chk({tag, " stall_cnt"}, stall_cnt, 0);
  endtask

  initial begin
    clear_in();
    model_reset();
    w_in_valid = 0; w_srcb_ctrl = 0; w_rs2_data = 0;
    #12;
    check_reset_values("reset");
    #5 rst_n = 1;

    // 1: shift amount from rs2, one-cycle latency.
    tick();
    in_valid = 1; srca_ctrl = 2'b00; rs1_addr = 1; rs1_data = 32'h10;
    srcb_ctrl = 3'b100; rs2_addr = 2; rs2_data = 32'hFFFF_FFE3;
    tick();
    pin("t1 out_valid", out_valid, m_valid, 1);
    pin("t1 srcb", srcb, m_b, 32'h3);
    clear_in(); tick();

    // 2: youngest forwarding port wins.
    in_valid = 1; srca_ctrl = 2'b00; rs1_addr = 5; rs1_data = 32'h99; srcb_ctrl = 3'b010;
    fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; fwd_data = {32'h22, 32'h11};
    tick();
    pin("t2 srca", srca, m_a, 32'h11);
    clear_in(); tick();

    // 3: load-use on rs2, producer pending for three cycles.
    in_valid = 1; out_ready = 0; srca_ctrl = 2'b01; pc = 32'h100;
    srcb_ctrl = 3'b000; rs2_addr = 7; rs2_data = 32'h77;
    fwd_valid = 2'b10; fwd_pend = 2'b10; fwd_rd = {5'd7, 5'd0}; fwd_data = {32'hDEAD, 32'h0};
    tick();
    pin("t3 out_valid a", out_valid, m_valid, 0);
    in_valid = 0;
    tick();
    pin("t3 out_valid b", out_valid, m_valid, 0);
    tick();
    fwd_pend = 2'b00; fwd_data = {32'hAB, 32'h0};
    tick();
    pin("t3 out_valid", out_valid, m_valid, 1);
    pin("t3 srcb", srcb, m_b, 32'hAB);
    pin("t3 sdata", sdata, m_s, 32'hAB);
    pin("t3 srca", srca, m_a, 32'h100);
    pin("t3 stall_cnt", stall_cnt, m_cnt, 3);

    // 4: backpressure holds outputs; then one instruction per cycle.
    fwd_valid = 0; fwd_pend = 0;
    in_valid = 1; srca_ctrl = 2'b10; srcb_ctrl = 3'b001; imm = 32'h5;
    for (int c = 0; c < 4; c++) begin
      #1;
      pin("t4 in_ready", in_ready, exp_ready(), 0);
      tick();
      pin("t4 hold srcb", srcb, m_b, 32'hAB);
      pin("t4 hold valid", out_valid, m_valid, 1);
    end
    out_ready = 1;
    for (int c = 1; c <= 4; c++) begin
      imm = 32'h111 * c;
      #1;
      pin("t4 b2b in_ready", in_ready, exp_ready(), 1);
      tick();
      pin("t4 b2b srcb", srcb, m_b, 32'h111 * c);
    end
    clear_in(); tick();

    // 5: flush while waiting, with a new instruction on the input.
    in_valid = 1; srca_ctrl = 2'b00; rs1_addr = 3;
    fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_rd = {5'd0, 5'd3};
    tick();
    flush = 1; srca_ctrl = 2'b10; srcb_ctrl = 3'b001; imm = 32'h5A;
    #1;
    pin("t5 in_ready", in_ready, exp_ready(), 0);
    tick();
    pin("t5 out_valid", out_valid, m_valid, 0);
    clear_in();
    tick();
    pin("t5 not accepted", out_valid, m_valid, 0);

    // 6: x0 never forwarded; XLEN/8 constant.
    in_valid = 1; srca_ctrl = 2'b00; rs1_addr = 0; rs1_data = 32'h99; srcb_ctrl = 3'b010;
    fwd_valid = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'h55};
    tick();
    pin("t6 srca", srca, m_a, 0);
    pin("t6 srcb", srcb, m_b, 4);
    clear_in();
    w_in_valid = 1; w_srcb_ctrl = 3'b010;
    tick();
    chk("t6 w64 out_valid", w_out_valid, 1);
    chk("t6 w64 srcb", w_srcb, 64'd8);
    w_srcb_ctrl = 3'b100; w_rs2_data = 64'hFFFF_FFFF_FFFF_FFC5;
    tick();
    chk("t6 w64 shamt", w_srcb, 64'd5);
    w_in_valid = 0;
    tick();

    // Reset in the middle of WAIT.
    in_valid = 1; srca_ctrl = 2'b00; rs1_addr = 4;
    fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_rd = {5'd0, 5'd4};
    tick();
    in_valid = 0;
    tick();
    #2 rst_n = 0;
    model_reset();
    #1 check_reset_values("midwait reset");
    #3 rst_n = 1;
    clear_in();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 24) == 0;
      store     = ($urandom % 5) == 0;
      srca_ctrl = 2'($urandom % 4);
      srcb_ctrl = 3'($urandom % 8);
      rs1_addr  = 5'($urandom % 4);
      rs2_addr  = 5'($urandom % 4);
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      pc        = $urandom;
      imm       = $urandom;
      for (int k = 0; k < int'(NF); k++) begin
        fwd_valid[k]        = ($urandom % 3) != 0;
        fwd_pend[k]         = ($urandom % 3) == 0;
        fwd_rd[5*k +: 5]    = 5'($urandom % 4);
        fwd_data[32*k +: 32] = $urandom;
      end
      tick();
    end
    clear_in();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
